// File: rtl/led_seq_if.sv
// led_seq_if: request/status bundle between the game controller and led_sequencer
//   show, color[1:0], speed, all_leds : controller -> sequencer display requests
//   busy, done                        : sequencer -> controller status
interface led_seq_if;
  logic       show;
  logic [1:0] color;
  logic       speed;
  logic       all_leds;
  logic       busy;
  logic       done;
  modport master (output show, color, speed, all_leds, input busy, done);
  modport slave  (input show, color, speed, all_leds, output busy, done);
endinterface

// File: rtl/led_sequencer.sv
// led_sequencer: turns one-cycle display requests into timed activity on four colour LEDs
//   clk, rst_n            : clock, asynchronous active-low reset
//   bus (led_seq_if.slave): show/color/speed/all_leds requests in, busy/done status out
//   led_red/green/blue/yellow : registered active-high LED drives
module led_sequencer #(
  parameter int CNT_W      = 32,
  parameter int ON_FAST    = 10,
  parameter int ON_SLOW    = 20,
  parameter int GAP        = 5,
  parameter int FLASH_ON   = 10,
  parameter int FLASH_REPS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  led_seq_if.slave    bus,
  output logic        led_red,
  output logic        led_green,
  output logic        led_blue,
  output logic        led_yellow
);
  localparam int REP_W = $clog2(FLASH_REPS + 1);
  typedef enum logic [2:0] {S_IDLE, S_ON, S_GAP, S_FL_ON, S_FL_OFF} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lim;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [1:0]       col_q, col_d;
  logic             spd_q, spd_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [3:0]       led_q, led_d;
  logic             last;
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    spd_d   = spd_q;
    rep_d   = rep_q;
    lim     = state_q == S_ON  ? (spd_q ? CNT_W'(ON_FAST) : CNT_W'(ON_SLOW)) :
              state_q == S_GAP ? CNT_W'(GAP) :
              state_q == S_IDLE ? CNT_W'(1) : CNT_W'(FLASH_ON);
    last    = cnt_q == lim - CNT_W'(1);
    case (state_q)
      S_IDLE:
        if (bus.all_leds) begin
          state_d = S_FL_ON;
          rep_d   = '0;
        end else if (bus.show) begin
          state_d = S_ON;
          col_d   = bus.color;
          spd_d   = bus.speed;
        end
      S_ON:    state_d = last ? S_GAP : S_ON;
      S_GAP:   state_d = last ? S_IDLE : S_GAP;
      S_FL_ON: state_d = last ? S_FL_OFF : S_FL_ON;
      S_FL_OFF:
        if (last) begin
          rep_d   = rep_q + REP_W'(1);
          state_d = rep_d < REP_W'(FLASH_REPS) ? S_FL_ON : S_IDLE;
        end
      default: state_d = S_IDLE;
    endcase
    // Timer restarts on every state change and rests at zero in IDLE.
    cnt_d  = (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + CNT_W'(1);
    // Outputs are registered from the next state so they align with it.
    busy_d = state_d != S_IDLE;
    done_d = state_d == S_IDLE && state_q != S_IDLE;
    led_d  = state_d == S_FL_ON ? 4'hf : state_d == S_ON ? 4'b0001 << col_d : 4'h0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rep_q   <= '0;
      col_q   <= '0;
      spd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      col_q   <= col_d;
      spd_q   <= spd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      led_q   <= led_d;
    end
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign led_red    = led_q[0];
  assign led_green  = led_q[1];
  assign led_blue   = led_q[2];
  assign led_yellow = led_q[3];
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: scoreboard bench for led_sequencer
module tb_led_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic led_red, led_green, led_blue, led_yellow;
  led_seq_if bus();
  led_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus), .led_red(led_red),
                     .led_green(led_green), .led_blue(led_blue), .led_yellow(led_yellow));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] pat;
    int         on;
    int         rises;
    int         busy;
    bit         stream;
  } exp_t;
  exp_t sbq[$];
  int tests = 0, fails = 0, inv = 0, aborts = 0;
  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  function automatic exp_t mk(logic [3:0] pat, int on, int rises, int busy, bit stream);
    exp_t e;
    e.pat = pat; e.on = on; e.rises = rises; e.busy = busy; e.stream = stream;
    return e;
  endfunction
  initial begin
    logic [3:0] led, prev_led, pat;
    bit prev_busy;
    int bcnt, oncnt, rises, bad, idle, start_idle;
    exp_t e;
    prev_led = 0; prev_busy = 0; pat = 0;
    bcnt = 0; oncnt = 0; rises = 0; bad = 0; idle = 0; start_idle = 0;
    forever begin
      @(negedge clk);
      led = {led_yellow, led_blue, led_green, led_red};
      if (bus.busy && bus.done) inv++;
      if (!($countones(led) inside {0, 1, 4})) inv++;
      if (!bus.busy && led != 0) inv++;
      if (bus.busy) begin
        if (!prev_busy) begin
          bcnt = 0; oncnt = 0; rises = 0; bad = 0; pat = 0;
          start_idle = idle; idle = 0;
        end
        bcnt++;
        if (led != 0) begin
          if (pat == 0) pat = led;
          if (led == pat) oncnt++; else bad++;
          if (prev_led == 0) rises++;
        end
      end else begin
        idle++;
        if (bus.done) begin
          if (sbq.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = sbq.pop_front();
            chk("lit_pattern", int'(pat), int'(e.pat));
            chk("on_cycles", oncnt, e.on);
            chk("blinks", rises, e.rises);
            chk("busy_cycles", bcnt, e.busy);
            chk("stray_led_cycles", bad, 0);
            if (e.stream) chk("stream_idle", start_idle, 1);
          end
        end else if (prev_busy) aborts++;
      end
      prev_busy = bus.busy;
      prev_led = led;
    end
  end
  task automatic drain(int max);
    int n = 0;
    while (sbq.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);
    repeat (4) @(negedge clk);
  endtask
  task automatic wait_done(int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < max);
    chk("done_wait", int'(bus.done), 1);
  endtask
  task automatic slow_red;
    bus.show = 1; bus.color = 0; bus.speed = 0;
    sbq.push_back(mk(4'b0001, 20, 1, 25, 0));
    @(negedge clk);
    bus.show = 0;
    drain(100);
  endtask
  initial begin
    bus.show = 0; bus.color = 0; bus.speed = 0; bus.all_leds = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_leds", int'({led_yellow, led_blue, led_green, led_red}), 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    slow_red();
    bus.show = 1; bus.color = 3; bus.speed = 1;
    sbq.push_back(mk(4'b1000, 10, 1, 15, 0));
    @(negedge clk);
    bus.show = 0;
    repeat (2) @(negedge clk);
    bus.color = 1; bus.speed = 0;
    drain(100);
    bus.all_leds = 1; bus.show = 1; bus.color = 2;
    sbq.push_back(mk(4'b1111, 30, 3, 60, 0));
    @(negedge clk);
    bus.all_leds = 0; bus.show = 0;
    drain(200);
    bus.show = 1; bus.color = 2; bus.speed = 1;
    sbq.push_back(mk(4'b0100, 10, 1, 15, 0));
    @(negedge clk);
    bus.show = 0;
    repeat (3) @(negedge clk);
    bus.show = 1; bus.color = 0;
    @(negedge clk);
    bus.show = 0;
    repeat (8) @(negedge clk);
    bus.all_leds = 1;
    @(negedge clk);
    bus.all_leds = 0;
    drain(100);
    bus.show = 1; bus.color = 0; bus.speed = 1;
    sbq.push_back(mk(4'b0001, 10, 1, 15, 0));
    sbq.push_back(mk(4'b0010, 10, 1, 15, 1));
    sbq.push_back(mk(4'b0100, 10, 1, 15, 1));
    sbq.push_back(mk(4'b1000, 10, 1, 15, 1));
    for (int i = 1; i <= 4; i++) begin
      wait_done(40);
      if (i < 4) bus.color = 2'(i);
      else bus.show = 0;
    end
    drain(100);
    bus.show = 1; bus.color = 1; bus.speed = 0;
    @(negedge clk);
    bus.show = 0;
    repeat (6) @(negedge clk);
    chk("green_before_reset", int'(led_green), 1);
    #1 rst_n = 0;
    #1;
    chk("rst_green_low", int'(led_green), 0);
    chk("rst_busy_low", int'(bus.busy), 0);
    chk("rst_done_low", int'(bus.done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    slow_red();
    chk("aborts", aborts, 1);
    chk("invariants", inv, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
